// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Purpose  : round-robin grant of a shared 8:1 single-bit mux with bounded tenure
// Revision : 1.0
// ============================================================================
module rr_mux_arbiter #(
  parameter int N        = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     din,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     gnt,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [3:0]       hold_q, hold_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;

  logic [SEL_W-1:0] g_next;
  logic [N-1:0]     others;
  logic [SEL_W-1:0] arb_base;
  logic [N-1:0]     arb_req;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_found;

  assign g_next = sel_q + SEL_W'(1);
  assign others = req & ~(N'(1) << sel_q);

  // In GRANT the search always starts just past the grantee with the grantee
  // masked; on release req[sel] is already low so this also covers that case.
  always_comb begin
    arb_base = ptr_q;
    arb_req  = req;
    if (state_q == GRANT) begin
      arb_base = g_next;
      arb_req  = others;
    end
  end

  // Descending scan so the smallest offset from arb_base wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (arb_req[arb_base + SEL_W'(i)]) begin
        arb_found = 1'b1;
        arb_idx   = arb_base + SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    dout_d  = din[sel_q];
    valid_d = (state_q == GRANT) && req[sel_q];

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = GRANT;
          sel_d   = arb_idx;
          gnt_d   = N'(1) << arb_idx;
          hold_d  = 4'd1;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          ptr_d = g_next;
          if (arb_found) begin
            sel_d  = arb_idx;
            gnt_d  = N'(1) << arb_idx;
            hold_d = 4'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if ((hold_q == c_max_hold) && arb_found) begin
          ptr_d  = g_next;
          sel_d  = arb_idx;
          gnt_d  = N'(1) << arb_idx;
          hold_d = 4'd1;
        end else if (hold_q != c_max_hold) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign sel        = sel_q;
  assign gnt        = gnt_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q == GRANT);

endmodule
`default_nettype wire
